// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative multiply/divide sequencer.
package muldiv_pkg;

  localparam int DEFAULT_WIDTH = 32;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_e;

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration of the multiply/divide datapath: a radix-2 Booth
// step (op = MULT) or a restoring-division step (op = DIV) on the shared accumulator.
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                 op,
  input  logic [2*WIDTH+1:0]   acc_i,
  input  logic [WIDTH:0]       opnd_i,
  output logic [2*WIDTH+1:0]   acc_o
);

  localparam int AW = 2 * WIDTH + 2;

  // Accumulator layout: [AW-1:WIDTH+1] partial product / remainder,
  // [WIDTH:1] multiplier / quotient, [0] Booth look-behind bit.
  logic [WIDTH:0]   upper;
  logic [WIDTH:0]   upper_sum;
  logic [AW-1:0]    booth_acc;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH+1:0] trial;
  logic [AW-1:0]    div_acc;

  always_comb begin
    upper = acc_i[AW-1:WIDTH+1];
    case (acc_i[1:0])
      2'b01:   upper_sum = upper + opnd_i;
      2'b10:   upper_sum = upper - opnd_i;
      default: upper_sum = upper;
    endcase
    booth_acc = {upper_sum[WIDTH], upper_sum, acc_i[WIDTH:1]};

    // The remainder never exceeds the divisor, so its top field bit stays zero.
    rem_sh  = {acc_i[2*WIDTH:WIDTH+1], acc_i[WIDTH]};
    trial   = {1'b0, rem_sh} - {1'b0, opnd_i};
    div_acc = {(trial[WIDTH+1] ? rem_sh : trial[WIDTH:0]),
               acc_i[WIDTH-1:1], ~trial[WIDTH+1], 1'b0};

    acc_o = (op == OP_DIV) ? div_acc : booth_acc;
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// Multiply/divide sequencer owning HI/LO. Define MULDIV_UNSIGNED_EN to add the
// 'uns' input selecting MULTU/DIVU; otherwise every operation is signed.
module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter  int WIDTH = DEFAULT_WIDTH,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
`ifdef MULDIV_UNSIGNED_EN
  input  logic             uns,
`endif
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [1:0]       dbg_state
);

  localparam int AW = 2 * WIDTH + 2;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [AW-1:0]    acc_q, acc_d;
  logic [WIDTH:0]   opnd_q, opnd_d;
  logic             op_q, op_d;
  logic             sign_a_q, sign_a_d;
  logic             neg_quo_q, neg_quo_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             done_q, done_d;
  logic             dz_q, dz_d;
`ifdef MULDIV_UNSIGNED_EN
  logic             uns_q, uns_d;
`endif

  logic             signed_op;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_abs, b_abs;
  logic [AW-1:0]    step_acc;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0] quo, rem;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .op     (op_q),
    .acc_i  (acc_q),
    .opnd_i (opnd_q),
    .acc_o  (step_acc)
  );

  always_comb begin
`ifdef MULDIV_UNSIGNED_EN
    signed_op = ~uns;
`else
    signed_op = 1'b1;
`endif
    a_neg = signed_op & a[WIDTH-1];
    b_neg = signed_op & b[WIDTH-1];
    a_abs = a_neg ? (WIDTH'(0) - a) : a;
    b_abs = b_neg ? (WIDTH'(0) - b) : b;

    prod = acc_q[2*WIDTH:1];
`ifdef MULDIV_UNSIGNED_EN
    // Final Booth step for a zero-extended multiplier: its implicit top 0 pairs
    // with b's MSB, adding the multiplicand once more at weight 2^WIDTH.
    if (uns_q && acc_q[0]) prod[2*WIDTH-1:WIDTH] = prod[2*WIDTH-1:WIDTH] + opnd_q[WIDTH-1:0];
`endif
    quo = acc_q[WIDTH:1];
    rem = acc_q[2*WIDTH:WIDTH+1];
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    op_d      = op_q;
    sign_a_d  = sign_a_q;
    neg_quo_d = neg_quo_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    dz_d      = 1'b0;
`ifdef MULDIV_UNSIGNED_EN
    uns_d     = uns_q;
`endif

    case (state_q)
      IDLE: begin
        if (start) begin
          op_d      = op;
          cnt_d     = '0;
          sign_a_d  = a_neg;
          neg_quo_d = a_neg ^ b_neg;
`ifdef MULDIV_UNSIGNED_EN
          uns_d     = uns;
`endif
          if (op == OP_MULT) begin
            opnd_d  = {signed_op & a[WIDTH-1], a};
            acc_d   = {{(WIDTH+1){1'b0}}, b, 1'b0};
            state_d = RUN;
          end else begin
            // A zero divisor leaves opnd at zero, which FIN uses to flag it.
            opnd_d = {1'b0, b_abs};
            if (b == '0) begin
              state_d = FIN;
            end else begin
              acc_d   = {{(WIDTH+1){1'b0}}, a_abs, 1'b0};
              state_d = RUN;
            end
          end
        end
      end
      RUN: begin
        acc_d = step_acc;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(WIDTH - 1)) state_d = FIN;
      end
      FIN: begin
        state_d = IDLE;
        done_d  = 1'b1;
        if (op_q == OP_MULT) begin
          {hi_d, lo_d} = prod;
        end else if (opnd_q == '0) begin
          dz_d = 1'b1;
        end else begin
          lo_d = neg_quo_q ? (WIDTH'(0) - quo) : quo;
          hi_d = sign_a_q ? (WIDTH'(0) - rem) : rem;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      opnd_q    <= '0;
      op_q      <= OP_MULT;
      sign_a_q  <= 1'b0;
      neg_quo_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
      dz_q      <= 1'b0;
`ifdef MULDIV_UNSIGNED_EN
      uns_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      op_q      <= op_d;
      sign_a_q  <= sign_a_d;
      neg_quo_q <= neg_quo_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
      dz_q      <= dz_d;
`ifdef MULDIV_UNSIGNED_EN
      uns_q     <= uns_d;
`endif
    end
  end

  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign div_zero  = dz_q;
  assign hi        = hi_q;
  assign lo        = lo_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Bench for muldiv_ctrl: directed and random signed MULT/DIV against an
// arithmetic reference model, with a done-driven scoreboard monitor.
module tb_muldiv_ctrl;
  import muldiv_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         op;
  logic [W-1:0] a, b;
  logic         busy, done, div_zero;
  logic [W-1:0] hi, lo;
  logic [1:0]   dbg_state;
`ifdef MULDIV_UNSIGNED_EN
  logic         uns = 1'b0;
`endif

  muldiv_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .op        (op),
`ifdef MULDIV_UNSIGNED_EN
    .uns       (uns),
`endif
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .div_zero  (div_zero),
    .hi        (hi),
    .lo        (lo),
    .dbg_state (dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Expected {div_zero, hi, lo} per accepted operation
  logic [2*W:0] exp_q[$];
  logic [2*W:0] mon_e;
  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Reference model: plain signed arithmetic on 64-bit integers.
  function automatic void model(input logic o, input logic [W-1:0] x, input logic [W-1:0] y);
    longint p, q, r;
    logic   dz;
    dz = 1'b0;
    if (o == OP_MULT) begin
      p    = longint'($signed(x)) * longint'($signed(y));
      m_hi = p[63:32];
      m_lo = p[31:0];
    end else if (y == '0) begin
      dz = 1'b1;
    end else begin
      q    = longint'($signed(x)) / longint'($signed(y));
      r    = longint'($signed(x)) % longint'($signed(y));
      m_lo = q[31:0];
      m_hi = r[31:0];
    end
    exp_q.push_back({dz, m_hi, m_lo});
  endfunction

  // Scoreboard monitor
  always @(negedge clk) begin
    if (!reset && done) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected no pending operation");
      end else begin
        mon_e = exp_q.pop_front();
        check("hi", hi, mon_e[2*W-1:W]);
        check("lo", lo, mon_e[W-1:0]);
        check("div_zero", div_zero, mon_e[2*W]);
      end
    end
  end

  // Driver: issue one op, optionally glitch start or assert reset mid-flight.
  task automatic run_op(input logic o, input logic [W-1:0] x, input logic [W-1:0] y,
                        input int glitch_at, input int reset_at);
    int cyc;
    int exp_busy;
    exp_busy = (o == OP_DIV && y == '0) ? 1 : W + 1;
    op = o; a = x; b = y; start = 1'b1;
    model(o, x, y);
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    check("busy_after_start", busy, 1);
    while (busy && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
      start = 1'b0;
      if (cyc == glitch_at) begin
        start = 1'b1; op = 1'($urandom); a = $urandom; b = $urandom;
      end
      if (cyc == reset_at) begin
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        exp_q.delete();
        m_hi = '0;
        m_lo = '0;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_hi", hi, 0);
        check("abort_lo", lo, 0);
        return;
      end
    end
    check("busy_cycles", cyc, exp_busy);
  endtask

  logic         r_op;
  logic [W-1:0] r_a, r_b;

  initial begin
    reset = 1'b1; start = 1'b0; op = 1'b0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_div_zero", div_zero, 0);
    check("reset_hi", hi, 0);
    check("reset_lo", lo, 0);
    check("reset_state", dbg_state, IDLE);

    run_op(OP_MULT, 32'd7, 32'hFFFF_FFFD, -1, -1);
    run_op(OP_MULT, 32'h8000_0000, 32'h8000_0000, -1, -1);
    run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, -1, -1);
    run_op(OP_DIV, 32'd100, 32'd7, -1, -1);
    run_op(OP_DIV, 32'd104, 32'd11, -1, -1);
    run_op(OP_DIV, 32'd123, 32'd0, -1, -1);
    run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, -1, -1);
    run_op(OP_MULT, 32'd1234, 32'hFFFF_0000, 5, -1);
    run_op(OP_MULT, $urandom, $urandom, -1, 10);
    run_op(OP_MULT, 32'd3, 32'd4, -1, -1);

    for (int i = 0; i < 25; i++) begin
      r_op = 1'($urandom_range(0, 1));
      r_a  = $urandom;
      case ($urandom_range(0, 7))
        0:       r_b = '0;
        1:       r_b = W'($urandom_range(1, 15));
        2:       r_b = 32'hFFFF_FFFF;
        default: r_b = $urandom;
      endcase
      run_op(r_op, r_a, r_b, -1, -1);
    end

    repeat (3) @(posedge clk);
    #1;
    check("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/muldiv_ctrl.md
Name: muldiv_ctrl

Overview:
- Sequencer for the processor's iterative multiply/divide unit.
- Accepts a MULT or DIV request from the main control unit and latches the operands.
- Runs a 32-step iteration: radix-2 Booth for multiply, restoring division for divide.
- Owns the HI/LO architectural registers and raises busy so the control FSM can stall mfhi/mflo and further mult/div.

Parameters:
- WIDTH, 32, operand width. HI and LO are each WIDTH bits; the iteration count equals WIDTH.
- CNT_W, $clog2(WIDTH)+1, width of the iteration counter (derived, do not override).

Ports:
- clk  in  1  system clock, rising-edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request pulse; sampled only in IDLE.
- op  in  1  0 = MULT, 1 = DIV.
- a  in  WIDTH  multiplicand / dividend (rs).
- b  in  WIDTH  multiplier / divisor (rt).
- busy  out  1  high while an operation is in flight.
- done  out  1  one-cycle pulse when HI/LO are updated.
- div_zero  out  1  one-cycle pulse with done when a DIV had b == 0.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- Reset, one clock edge with reset=1:
  - state = IDLE; busy, done, div_zero = 0; hi, lo = 0.
  - Internal accumulator and counter are cleared.
  - Reset mid-operation aborts the operation with no HI/LO update.
- States: IDLE, RUN, FIN.
- IDLE:
  - On start=1 (edge E0): latch a, b and op; set counter to 0.
  - MULT: acc = {WIDTH'0, b, 1'b0}, then go to RUN.
  - DIV with b != 0: store |a| and |b| plus the sign flags; remainder = 0; go to RUN.
  - DIV with b == 0: go directly to FIN.
- RUN, one iteration per edge:
  - MULT Booth step on acc[1:0]: 01 adds a to the upper WIDTH+1 bits; 10 subtracts a; 00 and 11 do nothing. Then arithmetic shift right by 1 of the full 2*WIDTH+1 accumulator.
  - DIV restoring step: shift {rem, quo} left by 1, trial subtract |b|, and keep the result if non-negative, setting quo[0]=1.
  - Counter increments each edge; after the WIDTH-th edge (E32) go to FIN.
- FIN, edge E33 (E1 for divide-by-zero):
  - MULT: {hi, lo} = acc[2*WIDTH:1], the signed 64-bit product.
  - DIV: lo = quotient, truncated toward zero and negated if sign(a) != sign(b). hi = remainder, taking the sign of a.
  - DIV with b == 0: hi and lo keep their prior values; div_zero = 1.
  - In all cases done = 1 for exactly one cycle and state = IDLE.
- busy = 1 from after E0 until E33 (or E1); busy = (state != IDLE).
- start while busy is ignored; operands are not re-latched.
- start in the cycle where done = 1 is accepted, since state is already IDLE. This gives back-to-back operations with no bubble.
- Overflow case: DIV of 0x80000000 by 0xFFFFFFFF gives lo = 0x80000000, hi = 0. This is deterministic and not trapped.
- hi and lo change only at FIN or reset.

Optional Feature:
- Macro MULDIV_UNSIGNED_EN.
- Defined:
  - Adds input port uns (1 bit, sampled with start).
  - uns = 1 selects MULTU/DIVU: operands are zero-extended. Booth uses a 33-bit multiplicand, with one extra iteration absorbed so latency stays at 33. Division skips all sign handling.
- Undefined: the port is absent and every operation is signed.

Decomposition:
- Package muldiv_pkg holds:
  - state enum {IDLE, RUN, FIN}.
  - Constants OP_MULT = 1'b0 and OP_DIV = 1'b1.
  - Default WIDTH.
- Sub-module muldiv_step: purely combinational single iteration (Booth step or restoring step, selected by op), instantiated once.
- muldiv_ctrl keeps the FSM, counter, operand/sign latches and HI/LO.

Test Plan:
- MULT a=7, b=0xFFFFFFFD (-3) -> at E33 done=1, hi=0xFFFFFFFF, lo=0xFFFFFFEB; busy high for exactly 33 cycles.
- MULT a=b=0x80000000 -> hi=0x40000000, lo=0x00000000.
- DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). Then DIV 100/7 -> lo=14, hi=2.
- DIV with b=0 after a prior result hi=5, lo=9 -> done and div_zero at E1; hi=5 and lo=9 unchanged; busy high for 1 cycle.
- start pulsed at iteration 5 -> ignored, result matches the first op. start asserted in the done cycle -> second op completes 33 cycles later.
- reset asserted at iteration 10 -> next cycle busy=0, hi=lo=0, done never pulses. A following MULT 3*4 gives lo=12, hi=0.
